// File: rtl/posit_defines.sv
// Shared posit sizing helpers and special-word constants for the POF encoders/decoders.
package posit_defines;

    localparam int unsigned MaxWordWidth = 64;
    typedef logic [MaxWordWidth-1:0] word_max_t;

    function automatic int unsigned get_scale_width(input int unsigned n, input int unsigned es);
        return int'($clog2(n)) + es + 1;
    endfunction

    function automatic int unsigned get_fraction_width(input int unsigned n, input int unsigned es);
        return n - es - 3;
    endfunction

    function automatic int unsigned get_maxscale(input int unsigned n, input int unsigned es);
        return (n - 2) << es;
    endfunction

    function automatic word_max_t nar_word(input int unsigned n);
        return word_max_t'(1) << (n - 1);
    endfunction

    function automatic word_max_t maxpos_word(input int unsigned n);
        return (word_max_t'(1) << (n - 1)) - word_max_t'(1);
    endfunction

    function automatic word_max_t minpos_word(input int unsigned n);
        return word_max_t'(n > 0);
    endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a truncated posit body, saturating at maxpos and never reaching zero.
module posit_round_rne
    import posit_defines::*;
#(
    parameter int unsigned POSIT_WIDTH = 32
) (
    input  logic [POSIT_WIDTH-2:0] body,
    input  logic                   guard,
    input  logic                   sticky,
    output logic [POSIT_WIDTH-2:0] rounded
);
    localparam int unsigned BodyWidth = POSIT_WIDTH - 1;
    localparam word_max_t MaxposFull = maxpos_word(POSIT_WIDTH);
    localparam word_max_t MinposFull = minpos_word(POSIT_WIDTH);
    localparam logic [BodyWidth-1:0] Maxpos = MaxposFull[BodyWidth-1:0];
    localparam logic [BodyWidth-1:0] Minpos = MinposFull[BodyWidth-1:0];

    logic                 round_up;
    logic [BodyWidth-1:0] sum;

    always_comb begin
        // A maxpos body must not carry into the sign bit.
        round_up = guard & (body[0] | sticky) & (body != Maxpos);
        sum      = body + BodyWidth'(round_up);
        rounded  = (sum == '0) ? Minpos : sum;
    end

endmodule

// File: rtl/posit_normalize_pipe.sv
// Three-stage pipelined posit encoder: clamp/decompose, regime assembly, round and sign.
module posit_normalize_pipe
    import posit_defines::*;
#(
    parameter int unsigned POSIT_WIDTH = 32,
    parameter int unsigned POSIT_ES    = 2,
    localparam int unsigned ScaleWidth = get_scale_width(POSIT_WIDTH, POSIT_ES),
    localparam int unsigned FracWidth  = get_fraction_width(POSIT_WIDTH, POSIT_ES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic                         sign_i,
    input  logic                         NaR_i,
    input  logic                         zero_i,
    input  logic signed [ScaleWidth-1:0] scale_i,
    input  logic [FracWidth-1:0]         fraction_i,
    input  logic                         sticky_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [POSIT_WIDTH-1:0]       posit_word_o
);
    localparam int unsigned N          = POSIT_WIDTH;
    localparam int unsigned ES         = POSIT_ES;
    localparam int unsigned TailWidth  = ES + FracWidth;
    localparam int unsigned ExtWidth   = N + TailWidth;
    localparam int unsigned ShiftWidth = $clog2(N);
    localparam int unsigned MaxScaleU  = get_maxscale(N, ES);
    localparam logic signed [ScaleWidth-1:0] MaxScale = ScaleWidth'(MaxScaleU);
    localparam logic signed [ScaleWidth-1:0] MinScale = -MaxScale;
    localparam word_max_t NarFull = nar_word(N);
    localparam logic [N-1:0] NarWord = NarFull[N-1:0];

    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    always_comb begin
        load3 = ~v3_q | m_ready_i;
        load2 = ~v2_q | load3;
        load1 = ~v1_q | load2;
    end

    assign s_ready_o = load1;

    // S1: clamp the scale and split it into regime run length and exponent bits.
    logic signed [ScaleWidth-1:0] scale_clamped, k_c;
    logic [ScaleWidth-1:0]        k_mag;
    logic [TailWidth-1:0]         tail_c;

    always_comb begin
        if (scale_i > MaxScale) begin
            scale_clamped = MaxScale;
        end else if (scale_i < MinScale) begin
            scale_clamped = MinScale;
        end else begin
            scale_clamped = scale_i;
        end
        k_c   = scale_clamped >>> ES;
        // Regime length minus two: k for k >= 0, -k-1 (= ~k) for k < 0.
        k_mag = k_c[ScaleWidth-1] ? ~k_c : k_c;
    end

    if (ES > 0) begin : g_exp
        assign tail_c = {scale_clamped[ES-1:0], fraction_i};
    end else begin : g_noexp
        assign tail_c = fraction_i;
    end

    logic                  sign1_q, nar1_q, zero1_q, kneg1_q, sticky1_q;
    logic [ShiftWidth-1:0] shift1_q;
    logic [TailWidth-1:0]  tail1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (load1) begin
            v1_q <= s_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (load1 && s_valid_i) begin
            sign1_q   <= sign_i;
            nar1_q    <= NaR_i;
            zero1_q   <= zero_i & ~NaR_i;
            kneg1_q   <= k_c[ScaleWidth-1];
            shift1_q  <= k_mag[ShiftWidth-1:0];
            tail1_q   <= tail_c;
            sticky1_q <= sticky_i;
        end
    end

    // S2: seed "10"/"01" above the tail and sign-extend it to grow the regime run.
    logic [ExtWidth-1:0] ext_c;
    logic [N-2:0]        body_c;
    logic                guard_c, sticky_c;

    always_comb begin
        ext_c    = $unsigned($signed({~kneg1_q, kneg1_q, tail1_q, {(N - 2){1'b0}}}) >>> shift1_q);
        body_c   = ext_c[ExtWidth-1 -: N-1];
        guard_c  = ext_c[TailWidth];
        sticky_c = (|ext_c[TailWidth-1:0]) | sticky1_q;
    end

    logic         sign2_q, nar2_q, zero2_q, guard2_q, sticky2_q;
    logic [N-2:0] body2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (load2) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (load2 && v1_q) begin
            sign2_q   <= sign1_q;
            nar2_q    <= nar1_q;
            zero2_q   <= zero1_q;
            body2_q   <= body_c;
            guard2_q  <= guard_c;
            sticky2_q <= sticky_c;
        end
    end

    // S3: round, apply sign, substitute specials.
    logic [N-2:0] rounded_c;
    logic [N-1:0] mag_c, word_c, word_q;

    posit_round_rne #(
        .POSIT_WIDTH(N)
    ) u_round (
        .body   (body2_q),
        .guard  (guard2_q),
        .sticky (sticky2_q),
        .rounded(rounded_c)
    );

    always_comb begin
        mag_c = {1'b0, rounded_c};
        if (nar2_q) begin
            word_c = NarWord;
        end else if (zero2_q) begin
            word_c = '0;
        end else if (sign2_q) begin
            word_c = '0 - mag_c;
        end else begin
            word_c = mag_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            word_q <= '0;
        end else if (load3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                word_q <= word_c;
            end
        end
    end

    assign m_valid_o    = v3_q;
    assign posit_word_o = word_q;

endmodule

// File: tb/tb_posit_normalize_pipe.sv
// Bench for posit_normalize_pipe (N=32, ES=2): directed table, scoreboard vs bit-string model.
module tb_posit_normalize_pipe;
    localparam int unsigned N  = 32;
    localparam int unsigned ES = 2;
    localparam int unsigned SW = 8;
    localparam int unsigned FW = 27;
    localparam int MaxScale = (N - 2) * (1 << ES);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid_i = 1'b0;
    logic                 s_ready_o;
    logic                 sign_i = 1'b0;
    logic                 NaR_i = 1'b0;
    logic                 zero_i = 1'b0;
    logic signed [SW-1:0] scale_i = '0;
    logic [FW-1:0]        fraction_i = '0;
    logic                 sticky_i = 1'b0;
    logic                 m_valid_o;
    logic                 m_ready_i = 1'b1;
    logic [N-1:0]         posit_word_o;

    posit_normalize_pipe #(
        .POSIT_WIDTH(N),
        .POSIT_ES   (ES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .sign_i      (sign_i),
        .NaR_i       (NaR_i),
        .zero_i      (zero_i),
        .scale_i     (scale_i),
        .fraction_i  (fraction_i),
        .sticky_i    (sticky_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .posit_word_o(posit_word_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: write the posit as a literal bit string, then truncate and round.
    function automatic logic [31:0] model(input logic sg, input logic nr, input logic zr,
                                          input int sc, input logic [FW-1:0] fr,
                                          input logic stk);
        bit     q[$];
        longint body;
        int     s, k, e;
        bit     guard, st;
        if (nr) return 32'h8000_0000;
        if (zr) return 32'h0;
        s = sc;
        if (s > MaxScale) s = MaxScale;
        if (s < -MaxScale) s = -MaxScale;
        k = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        e = s - 4 * k;
        if (k >= 0) begin
            for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = ES - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
        for (int i = FW - 1; i >= 0; i--) q.push_back(fr[i]);
        body = 0;
        for (int i = 0; i < N - 1; i++) body = body * 2 + longint'(q[i]);
        guard = (q.size() > N - 1) ? q[N-1] : 1'b0;
        st = stk;
        for (int i = N; i < q.size(); i++) st |= q[i];
        if (guard && ((body % 2) == 1 || st) && body != 64'h7FFF_FFFF) body++;
        if (body == 0) body = 1;
        if (sg) body = 64'h1_0000_0000 - body;
        return body[31:0];
    endfunction

    // Scoreboard and handshake monitor, sampled on the falling edge.
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("s_ready", 32'(s_ready_o), 32'((exp_q.size() < 3) || m_ready_i));
            if (prev_stall) check("stall_hold", posit_word_o, prev_word);
            if (exp_q.size() == 0) begin
                check("no_stale_valid", 32'(m_valid_o), 32'd0);
            end else if (m_valid_o && m_ready_i) begin
                check("stream_word", posit_word_o, exp_q.pop_front());
            end
            if (s_valid_i && s_ready_o)
                exp_q.push_back(model(sign_i, NaR_i, zero_i, int'(scale_i), fraction_i, sticky_i));
            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = posit_word_o;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic drive_beat(input logic sg, input logic nr, input logic zr, input int sc,
                              input logic [FW-1:0] fr, input logic stk);
        int n = 0;
        sign_i = sg; NaR_i = nr; zero_i = zr;
        scale_i = SW'(sc); fraction_i = fr; sticky_i = stk;
        s_valid_i = 1'b1;
        @(negedge clk);
        while (!s_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready_o 0 want 1 at %0t", $time);
        end
        @(posedge clk);
        #1 s_valid_i = 1'b0;
    endtask

    typedef struct {
        logic        sg, nr, zr;
        int          sc;
        logic [26:0] fr;
        logic        stk;
        logic [31:0] want;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic sg, input logic nr, input logic zr, input int sc,
                                input logic [26:0] fr, input logic stk, input logic [31:0] want);
        vec_t v;
        v.sg = sg; v.nr = nr; v.zr = zr; v.sc = sc; v.fr = fr; v.stk = stk; v.want = want;
        tbl.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v);
        drive_beat(v.sg, v.nr, v.zr, v.sc, v.fr, v.stk);
        @(posedge clk);
        @(negedge clk);
        check("latency_early", 32'(m_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency_valid", 32'(m_valid_o), 32'd1);
        check("table_word", posit_word_o, v.want);
        @(posedge clk);
        #1;
    endtask

    logic drv_done = 1'b0;

    initial begin
        add(1, 1, 0, 5, 27'd123, 1, 32'h8000_0000);
        add(0, 0, 1, 9, 27'd77, 1, 32'h0000_0000);
        add(1, 0, 1, 3, 27'd0, 0, 32'h0000_0000);
        add(0, 1, 1, 0, 27'd0, 0, 32'h8000_0000);
        add(0, 0, 0, 0, 27'd0, 0, 32'h4000_0000);
        add(1, 0, 0, 0, 27'd0, 0, 32'hC000_0000);
        add(0, 0, 0, 1, 27'd0, 0, 32'h4800_0000);
        add(0, 0, 0, -1, 27'd0, 0, 32'h3800_0000);
        add(0, 0, 0, 4, 27'd0, 0, 32'h6000_0000);
        add(0, 0, 0, 4, 27'd1, 0, 32'h6000_0000);
        add(0, 0, 0, 4, 27'd3, 0, 32'h6000_0002);
        add(0, 0, 0, 4, 27'd1, 1, 32'h6000_0001);
        add(0, 0, 0, 120, 27'd0, 0, 32'h7FFF_FFFF);
        add(0, 0, 0, 127, 27'd0, 0, 32'h7FFF_FFFF);
        add(0, 0, 0, -120, 27'd0, 0, 32'h0000_0001);
        add(0, 0, 0, -128, 27'd0, 0, 32'h0000_0001);
        add(1, 0, 0, 127, 27'd0, 0, 32'h8000_0001);
        add(0, 0, 0, -4, 27'd0, 0, 32'h2000_0000);
        add(0, 0, 0, 2, 27'h400_0000, 0, 32'h5400_0000);
        add(0, 0, 0, 0, 27'd0, 1, 32'h4000_0000);
        add(0, 0, 0, 118, 27'd0, 0, 32'h7FFF_FFFE);
        add(0, 0, 0, 119, 27'd0, 0, 32'h7FFF_FFFF);
        add(0, 0, 0, -117, 27'd0, 0, 32'h0000_0002);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_valid", 32'(m_valid_o), 32'd0);
        check("reset_s_ready", 32'(s_ready_o), 32'd1);
        check("reset_word", posit_word_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready_i = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Full-rate burst.
        for (int i = 0; i < 8; i++)
            drive_beat(1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 255)) - 128,
                       27'($urandom), 1'($urandom));
        repeat (5) @(posedge clk);
        #1;

        // Random backpressure stream.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int gap = int'($urandom_range(0, 3)) - 1;
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    drive_beat(1'($urandom), $urandom_range(0, 15) == 0,
                               $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)) - 128,
                               27'($urandom), 1'($urandom));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 m_ready_i = 1'($urandom);
                end
            end
        join
        m_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Fill the pipe with three stalled beats, then reset it mid-stream.
        m_ready_i = 1'b0;
        drive_beat(0, 0, 0, 0, 27'd0, 0);
        drive_beat(0, 0, 0, 1, 27'd0, 0);
        drive_beat(0, 0, 0, -1, 27'd0, 0);
        @(negedge clk);
        check("full_not_ready", 32'(s_ready_o), 32'd0);
        check("full_head_valid", 32'(m_valid_o), 32'd1);
        check("full_head_word", posit_word_o, 32'h4000_0000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid_o), 32'd0);
        check("midrst_s_ready", 32'(s_ready_o), 32'd1);
        check("midrst_word", posit_word_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        run_vec(tbl[10]);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
